alu_op_dispatcher: RTL and testbench

- Initiator side of the multicore ALU interface: accepts tagged operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues them one at a time onto the ALU's A/B/opcode bus, captures the registered 16-bit result and coreFlag, and returns a tagged response over a second valid/ready handshake.
- Checks that the answering core matches opcode[3:2] and flags unsupported ops.

---
 rtl/alu_op_dispatcher.sv | 127 ++++++++++++
 tb/tb_alu_op_dispatcher.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_dispatcher.sv
// Multicore ALU initiator: queues tagged requests, issues them one at a time
// to the registered ALU and returns tagged, error-checked responses.
module alu_op_dispatcher #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_A,
  input  logic [7:0]               req_B,
  input  logic [3:0]               req_opcode,
  input  logic [TAG_W-1:0]         req_tag,
  output logic [7:0]               alu_A,
  output logic [7:0]               alu_B,
  output logic [3:0]               alu_opcode,
  input  logic [15:0]              alu_result,
  input  logic [1:0]               alu_coreFlag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_result,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  req_t             mem [DEPTH];
  req_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  logic [TAG_W-1:0] op_tag;
  state_t           state;

  assign full      = (fifo_count == FULL_CNT);
  assign empty     = (fifo_count == '0);
  assign req_ready = !rst && !full;
  assign push      = req_valid && req_ready;
  // Pop only from registered occupancy, so a fresh push is never bypassed.
  assign pop       = !empty && ((state == IDLE) || (state == RESP && rsp_ready));
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: req_A, b: req_B, op: req_opcode, tag: req_tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // alu_opcode doubles as the opcode shadow: it is held until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_opcode <= '0;
      op_tag     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_A      <= head.a;
            alu_B      <= head.b;
            alu_opcode <= head.op;
            op_tag     <= head.tag;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          rsp_result <= alu_result;
          rsp_err    <= (alu_coreFlag != alu_opcode[3:2]) | (alu_opcode[1:0] == 2'b11);
          rsp_tag    <= op_tag;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_A      <= head.a;
              alu_B      <= head.b;
              alu_opcode <= head.op;
              op_tag     <= head.tag;
              state      <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Bench for alu_op_dispatcher: registered ALU stub, queue scoreboard,
// directed latency/backpressure/error/reset cases and a random phase.
module tb_alu_op_dispatcher;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [7:0]       req_A = '0, req_B = '0;
  logic [3:0]       req_opcode = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [7:0]       alu_A, alu_B;
  logic [3:0]       alu_opcode;
  logic [15:0]      alu_result = '0;
  logic [1:0]       alu_coreFlag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [15:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;
  logic [CW-1:0]    fifo_count;

  alu_op_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_opcode(req_opcode), .req_tag(req_tag),
    .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_coreFlag(alu_coreFlag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit bad_core = 1'b0;
  bit tput_on = 1'b0;
  int last_rsp = -1;

  typedef struct {
    logic [15:0]      res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
    case (op)
      2'd0:    return 16'(a) + 16'(b);
      2'd1:    return 16'(a) - 16'(b);
      2'd2:    return 16'(a) * 16'(b);
      default: return 16'h0;
    endcase
  endfunction

  // ALU stub: one-cycle registered result; bad_core makes core 3 answer as core 0
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    alu_result   <= alu_fn(alu_A, alu_B, alu_opcode[1:0]);
    alu_coreFlag <= (bad_core && alu_opcode == 4'hC) ? 2'b00 : alu_opcode[3:2];
  end

  // Scoreboard: sample handshakes mid-cycle, responses must match accepts in order
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("stale_rsp", 32'(1), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
          chk("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
        if (tput_on && last_rsp >= 0) chk("tput", 32'(cyc - last_rsp), 32'(3));
        last_rsp = cyc;
      end
      if (req_valid && req_ready)
        sb.push_back('{alu_fn(req_A, req_B, req_opcode[1:0]), req_tag,
                       (req_opcode[1:0] == 2'b11) || (bad_core && req_opcode == 4'hC)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic [TAG_W-1:0] tag);
    req_A = a; req_B = b; req_opcode = op; req_tag = tag;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [TAG_W-1:0] tag);
    int n = 0;
    drive(a, b, op, tag);
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin step(); n++; end
    if (n >= 50) chk("req_timeout", 32'(0), 32'(1));
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 500) begin step(); n++; end
    chk("drain_timeout", 32'(n < 500), 32'(1));
  endtask

  initial begin
    int n, acc;
    bit rdy, stable, saw;
    logic [15:0] s_res;
    logic [TAG_W-1:0] s_tag;
    logic [7:0] s_a, s_b;
    logic [3:0] s_op;

    // Reset state
    repeat (3) step();
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_fifo_count", 32'(fifo_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_alu", 32'({alu_A, alu_B, alu_opcode}), 32'(0));
    chk("rst_rsp", 32'({rsp_result, rsp_tag, rsp_err}), 32'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'(1));
    step();

    // Single add: 4-edge latency counting the accept edge
    rsp_ready = 1'b1;
    drive(8'd5, 8'd3, 4'b0000, 4'd1);
    req_valid = 1'b1;
    chk("add_ready", 32'(req_ready), 32'(1));
    step();
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk("latency", 32'(n), 32'(4));
    chk("add_result", 32'(rsp_result), 32'(16'h0008));
    chk("add_tag", 32'(rsp_tag), 32'(1));
    wait_drain();

    // Mul on core 2, sub on core 1
    send(8'd200, 8'd200, 4'b1010, 4'd2);
    send(8'd3, 8'd5, 4'b0101, 4'd3);
    wait_drain();

    // Backpressure: 5 fit (DEPTH queued + 1 in flight), 6th refused
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(8'(i * 17 + 1), 8'(i + 2), 4'((i % 4) * 4 + (i % 3)), 4'(8 + i));
      req_valid = 1'b1;
      rdy = req_ready;
      if (i == 5) chk("full_ready", 32'(rdy), 32'(0));
      if (rdy) acc++;
      step();
    end
    req_valid = 1'b0;
    chk("accepted", 32'(acc), 32'(5));
    chk("full_count", 32'(fifo_count), 32'(DEPTH));

    // Response stall: everything frozen for 10 cycles
    chk("stall_valid", 32'(rsp_valid), 32'(1));
    s_res = rsp_result; s_tag = rsp_tag; s_a = alu_A; s_b = alu_B; s_op = alu_opcode;
    stable = 1'b1;
    repeat (10) begin
      step();
      if (!rsp_valid || rsp_result !== s_res || rsp_tag !== s_tag || alu_A !== s_a ||
          alu_B !== s_b || alu_opcode !== s_op || fifo_count !== CW'(DEPTH)) stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'(1));
    tput_on = 1'b1;
    last_rsp = -1;
    rsp_ready = 1'b1;
    wait_drain();
    tput_on = 1'b0;

    // Error paths
    send(8'd9, 8'd4, 4'b0111, 4'd5);
    send(8'd7, 8'd9, 4'b1100, 4'd7);
    wait_drain();
    bad_core = 1'b1;
    send(8'd7, 8'd9, 4'b1100, 4'd6);
    wait_drain();
    bad_core = 1'b0;

    // Reset while in WAIT with 3 queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'(i + 10), 8'(i), 4'b0100, 4'(i));
      req_valid = 1'b1;
      step();
    end
    drive(8'd99, 8'd1, 4'b0000, 4'd4);
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    chk("pre_rst_count", 32'(fifo_count), 32'(3));
    chk("pre_rst_valid", 32'(rsp_valid), 32'(0));
    rst = 1'b1;
    #1;
    chk("rst_hi_ready", 32'(req_ready), 32'(0));
    step();
    chk("midrst_valid", 32'(rsp_valid), 32'(0));
    chk("midrst_count", 32'(fifo_count), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_ready", 32'(req_ready), 32'(0));
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 32'(req_ready), 32'(1));
    rsp_ready = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      step();
      if (rsp_valid) saw = 1'b1;
    end
    chk("no_stale", 32'(saw), 32'(0));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(8'($urandom), 8'($urandom), 4'($urandom), TAG_W'($urandom));
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      chk("ready_vs_count", 32'(req_ready), 32'(fifo_count != CW'(DEPTH)));
      chk("capacity", 32'(sb.size() <= DEPTH + 1), 32'(1));
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
